// File: rtl/unary_rate_acc.sv
// unary_rate_acc: decodes a unary rate-coded bitstream into a binary count.
// The block counts the 1s seen over a programmed number of valid bit-cycles.
// It then presents the result over a valid/ready handshake. Accepting a result
// and starting a new window can happen in the same cycle, so windows run
// back to back.
module unary_rate_acc #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_bit,
    input  logic             i_bit_valid,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] COUNT_MAX = '1;

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [LEN_W-1:0] remaining_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             busy_q;
    logic             handshake;
    logic             accept_start;

    assign handshake    = valid_q & i_ready;
    // A start is accepted from IDLE, or from HOLD in the cycle the result is taken.
    assign accept_start = i_start & ((state_q == IDLE) | ((state_q == HOLD) & handshake));

    // Saturating next count for the current bit.
    // NOTE: count_d gets a default before the conditional update, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (i_bit && (count_q != COUNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Window FSM with registered outputs.
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else if (accept_start) begin
            if (i_len != '0) begin
                state_q     <= ACC;
                remaining_q <= i_len;
                count_q     <= '0;
                valid_q     <= 1'b0;
                busy_q      <= 1'b1;
            end else begin
                // An empty window yields a zero result straight away.
                state_q <= HOLD;
                data_q  <= '0;
                valid_q <= 1'b1;
                busy_q  <= 1'b0;
            end
        end else begin
            case (state_q)
                ACC: begin
                    if (i_bit_valid) begin
                        count_q     <= count_d;
                        remaining_q <= remaining_q - 1'b1;
                        if (remaining_q == LEN_W'(1)) begin
                            state_q <= HOLD;
                            data_q  <= count_d;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (handshake) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_busy  = busy_q;
    assign o_data  = data_q;
    assign o_valid = valid_q;

endmodule

// File: tb/tb_unary_rate_acc.sv
// Directed testbench for unary_rate_acc. The DUT is built with a narrow result
// so saturation can be reached with a short window.
module tb_unary_rate_acc;

    localparam int WIDTH = 3;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_start;
    logic [LEN_W-1:0] i_len;
    logic             i_bit;
    logic             i_bit_valid;
    logic             o_busy;
    logic [WIDTH-1:0] o_data;
    logic             o_valid;
    logic             i_ready;

    int tests_run = 0;
    int tests_failed = 0;

    unary_rate_acc #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_len       (i_len),
        .i_bit       (i_bit),
        .i_bit_valid (i_bit_valid),
        .o_busy      (o_busy),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic v);
        i_bit       = b;
        i_bit_valid = v;
        step();
    endtask

    task automatic start_window(input logic [LEN_W-1:0] len);
        i_start = 1'b1;
        i_len   = len;
        step();
        i_start = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        logic [8:0] vpat;

        rst_n = 1'b0; i_start = 1'b0; i_len = '0; i_bit = 1'b0;
        i_bit_valid = 1'b0; i_ready = 1'b0;
        step(); step();
        check("rst_busy", o_busy, 0);
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        rst_n = 1'b1;

        // 1) len 8, bits 1,0,1,1,0,1,1,1; the start-cycle bit is not counted
        i_ready = 1'b1;
        i_bit = 1'b1; i_bit_valid = 1'b1;
        start_window(8);
        check("t1_busy", o_busy, 1);
        i_len = 8'd1;  // must not affect the running window
        pat = 8'b1110_1101;  // LSB first: 1,0,1,1,0,1,1,1
        for (int i = 0; i < 8; i++) begin
            check("t1_no_early_valid", o_valid, 0);
            send_bit(pat[i], 1'b1);
        end
        check("t1_valid", o_valid, 1);
        check("t1_data", o_data, 6);
        check("t1_busy_done", o_busy, 0);
        step();
        check("t1_idle_valid", o_valid, 0);
        check("t1_idle_busy", o_busy, 0);

        // 2) len 4 with valid gaps over 9 cycles, all bits 1
        i_bit_valid = 1'b0;
        start_window(4);
        vpat = 9'b1_0010_1001;  // valid on cycles 0,3,5,8
        for (int i = 0; i < 9; i++) begin
            check("t2_busy", o_busy, 1);
            send_bit(1'b1, vpat[i]);
        end
        check("t2_valid", o_valid, 1);
        check("t2_data", o_data, 4);
        check("t2_busy_done", o_busy, 0);
        step();
        check("t2_idle", o_valid, 0);

        // 3) backpressure on a result of 3; a start while held is ignored
        i_ready = 1'b0;
        start_window(3);
        send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1);
        i_bit_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", o_valid, 1);
            check("t3_hold_data", o_data, 3);
            i_start = (i == 2);
            i_len   = 8'd5;
            step();
        end
        i_start = 1'b0;
        check("t3_hold_valid_end", o_valid, 1);
        check("t3_hold_busy", o_busy, 0);
        i_ready = 1'b1;
        step();
        check("t3_released", o_valid, 0);
        step();
        check("t3_idle_busy", o_busy, 0);
        check("t3_idle_valid", o_valid, 0);

        // 4) back-to-back: handshake and start in the same cycle
        i_ready = 1'b0;
        start_window(1);
        send_bit(1'b1, 1'b1);
        i_bit_valid = 1'b0;
        check("t4_first_valid", o_valid, 1);
        check("t4_first_data", o_data, 1);
        i_ready = 1'b1;
        start_window(2);
        check("t4_b2b_busy", o_busy, 1);
        check("t4_b2b_valid", o_valid, 0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        check("t4_valid", o_valid, 1);
        check("t4_data", o_data, 2);
        i_bit_valid = 1'b0;
        step();
        check("t4_idle", o_valid, 0);

        // 5) zero-length window, then a start during ACC is ignored
        i_ready = 1'b0;
        start_window(0);
        check("t5_zero_valid", o_valid, 1);
        check("t5_zero_data", o_data, 0);
        check("t5_zero_busy", o_busy, 0);
        i_ready = 1'b1;
        step();
        check("t5_zero_released", o_valid, 0);
        start_window(3);
        i_start = 1'b1; i_len = 8'd1;
        send_bit(1'b1, 1'b1);
        i_start = 1'b0;
        check("t5_no_restart_busy", o_busy, 1);
        check("t5_no_restart_valid", o_valid, 0);
        send_bit(1'b1, 1'b1);
        check("t5_still_busy", o_busy, 1);
        send_bit(1'b1, 1'b1);
        check("t5_valid", o_valid, 1);
        check("t5_data", o_data, 3);
        i_bit_valid = 1'b0;
        step();

        // 6) reset mid-window discards the partial count
        start_window(8);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
        i_bit_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("t6_rst_busy", o_busy, 0);
        check("t6_rst_valid", o_valid, 0);
        check("t6_rst_data", o_data, 0);
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b1, 1'b1);
            check("t6_no_stale", o_valid, 0);
        end
        start_window(3);
        send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1);
        check("t6_valid", o_valid, 1);
        check("t6_data", o_data, 3);
        i_bit_valid = 1'b0;
        step();

        // 7) saturation: 10 ones into a 3-bit count stop at 7
        start_window(10);
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b1);
        i_bit_valid = 1'b0;
        check("t7_sat_valid", o_valid, 1);
        check("t7_sat_data", o_data, 7);
        step();
        check("t7_idle", o_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
